// File: rtl/thermo_uart_pkg.sv
// Shared constants and types for the temperature-to-ASCII UART framer.
package thermo_uart_pkg;

    localparam int TEMP_W_DEF = 12;
    localparam int FRAC_W_DEF = 4;

    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [1:0] {IDLE, CONVERT, SEND, WAIT} framer_state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/temp_ascii_framer_if.sv
// Sample input, uart_tx byte handshake and status flags of the framer.
interface temp_ascii_framer_if #(parameter int TEMP_W = 12);
    logic              temp_valid;
    logic [TEMP_W-1:0] temp_data;
    logic              tx_done_tick;
    logic              tx_start;
    logic [7:0]        data_byte;
    logic              busy;
    logic              drop_tick;

    modport master (input  temp_valid, temp_data, tx_done_tick,
                    output tx_start, data_byte, busy, drop_tick);
    modport slave  (output temp_valid, temp_data, tx_done_tick,
                    input  tx_start, data_byte, busy, drop_tick);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: IN_W-bit unsigned to three BCD digits in exactly IN_W cycles.
module bin2bcd_seq #(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            done,
    output logic [3:0]      hundreds,
    output logic [3:0]      tens,
    output logic [3:0]      ones
);
    logic [IN_W-1:0] shift_q;
    logic [11:0]     bcd_q;
    logic [11:0]     adj;
    logic [3:0]      cnt_q;
    logic            run_q;

    always_comb begin
        adj = bcd_q;
        for (int unsigned d = 0; d < 3; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shift_q <= bin;
                bcd_q   <= '0;
                cnt_q   <= '0;
                run_q   <= 1'b1;
            end else if (run_q) begin
                {bcd_q, shift_q} <= {adj, shift_q} << 1;
                cnt_q            <= cnt_q + 4'd1;
                if (cnt_q == 4'(IN_W - 1)) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign hundreds = bcd_q[11:8];
    assign tens     = bcd_q[7:4];
    assign ones     = bcd_q[3:0];
endmodule

// File: rtl/temp_ascii_framer.sv
// Frames a signed Q-format temperature sample as "+ddd.dC\r\n" and streams it to uart_tx.
module temp_ascii_framer
    import thermo_uart_pkg::*;
#(
    parameter int         TEMP_W    = TEMP_W_DEF,
    parameter int         FRAC_W    = FRAC_W_DEF,
    parameter logic [7:0] UNIT_CHAR = 8'h43,
    parameter bit         EOL_CRLF  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    temp_ascii_framer_if.master  bus
);
    localparam int              INT_W    = TEMP_W - FRAC_W;
    localparam logic [3:0]      LAST_IDX = EOL_CRLF ? 4'd8 : 4'd6;
    localparam logic [FRAC_W+3:0] TEN    = 10;

    framer_state_t     state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              load;
    logic [7:0]        byte_sel;
    logic [7:0]        data_q;
    logic              drop_q;
    logic              sign_q;
    logic [3:0]        frac_q;
    logic [TEMP_W-1:0] mag;
    logic [FRAC_W+3:0] frac_prod;
    logic [3:0]        frac_digit;
    logic              accept;
    logic              bcd_done;
    logic [3:0]        hund, tens, ones;

    // Magnitude of the most negative code still fits unsigned, giving integer part 128.
    assign mag        = bus.temp_data[TEMP_W-1] ? (~bus.temp_data + 1'b1) : bus.temp_data;
    assign frac_prod  = {4'h0, mag[FRAC_W-1:0]} * TEN;
    assign frac_digit = 4'(frac_prod >> FRAC_W);
    assign accept     = (state_q == IDLE) && bus.temp_valid;

    bin2bcd_seq #(.IN_W(INT_W)) u_bcd (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .bin      (mag[TEMP_W-1:FRAC_W]),
        .done     (bcd_done),
        .hundreds (hund),
        .tens     (tens),
        .ones     (ones)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            IDLE:    if (bus.temp_valid) state_d = CONVERT;
            CONVERT: if (bcd_done) begin
                         state_d = SEND;
                         idx_d   = '0;
                         load    = 1'b1;
                     end
            SEND:    state_d = WAIT;
            WAIT:    if (bus.tx_done_tick) begin
                         if (idx_q == LAST_IDX) begin
                             state_d = IDLE;
                         end else begin
                             state_d = SEND;
                             idx_d   = idx_q + 4'd1;
                             load    = 1'b1;
                         end
                     end
            default: state_d = IDLE;
        endcase

        byte_sel = '0;
        case (idx_d)
            4'd0:    byte_sel = sign_q ? ASCII_MINUS : ASCII_PLUS;
            4'd1:    byte_sel = digit_char(hund);
            4'd2:    byte_sel = digit_char(tens);
            4'd3:    byte_sel = digit_char(ones);
            4'd4:    byte_sel = ASCII_DOT;
            4'd5:    byte_sel = digit_char(frac_q);
            4'd6:    byte_sel = UNIT_CHAR;
            4'd7:    byte_sel = ASCII_CR;
            4'd8:    byte_sel = ASCII_LF;
            default: byte_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
            sign_q  <= 1'b0;
            frac_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= bus.temp_valid && (state_q != IDLE);
            if (load) data_q <= byte_sel;
            if (accept) begin
                sign_q <= bus.temp_data[TEMP_W-1];
                frac_q <= frac_digit;
            end
        end
    end

    assign bus.tx_start  = (state_q == SEND);
    assign bus.busy      = (state_q != IDLE);
    assign bus.data_byte = data_q;
    assign bus.drop_tick = drop_q;
endmodule

// File: tb/tb_temp_ascii_framer.sv
// Directed bench for temp_ascii_framer with a behavioural uart_tx done-tick responder.
module tb_temp_ascii_framer;
    logic clk;
    logic reset;
    logic sel;
    int   checks;
    int   failures;

    temp_ascii_framer_if #(.TEMP_W(12)) bus0 ();
    temp_ascii_framer_if #(.TEMP_W(12)) bus1 ();

    temp_ascii_framer #(.TEMP_W(12), .FRAC_W(4), .UNIT_CHAR(8'h43), .EOL_CRLF(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master));
    temp_ascii_framer #(.TEMP_W(12), .FRAC_W(4), .UNIT_CHAR(8'h43), .EOL_CRLF(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.master));

    logic       tx_start_s, busy_s, drop_s;
    logic [7:0] data_s;
    assign tx_start_s = sel ? bus1.tx_start  : bus0.tx_start;
    assign busy_s     = sel ? bus1.busy      : bus0.busy;
    assign drop_s     = sel ? bus1.drop_tick : bus0.drop_tick;
    assign data_s     = sel ? bus1.data_byte : bus0.data_byte;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) bus1.temp_valid = v;
        else     bus0.temp_valid = v;
    endtask

    task automatic set_done(input logic v);
        bus0.tx_done_tick = v;
        bus1.tx_done_tick = v;
    endtask

    task automatic no_line(input string tag);
        int seen;
        seen = 0;
        repeat (20) begin
            tick();
            if (tx_start_s) seen++;
        end
        chk({tag, "_no_tx"}, seen, 0);
        chk({tag, "_idle"}, busy_s, 1'b0);
    endtask

    // exp holds byte 0 in its top 8 bits; n is the number of bytes expected.
    task automatic run_line(input logic [11:0] t, input logic [71:0] expb, input int n,
                            input int drop_at, input int abort_at, input bit drop_end);
        int         cnt;
        logic [7:0] eb;
        bus0.temp_data = t;
        bus1.temp_data = t;
        set_valid(1'b1);
        tick();
        set_valid(1'b0);
        chk("busy_rise", busy_s, 1'b1);
        cnt = 0;
        while (!tx_start_s && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("latency", cnt, 9);
        for (int i = 0; i < n; i++) begin
            eb = expb[71 - 8*i -: 8];
            chk($sformatf("byte%0d", i), data_s, eb);
            tick();
            chk("start_width", tx_start_s, 1'b0);
            if (abort_at == i) begin
                #2 reset = 1'b0;
                #1;
                chk("rst_tx_start", tx_start_s, 1'b0);
                chk("rst_data", data_s, 8'h00);
                chk("rst_busy", busy_s, 1'b0);
                tick();
                tick();
                @(negedge clk);
                reset = 1'b1;
                tick();
                return;
            end
            if (drop_at == i) begin
                set_valid(1'b1);
                tick();
                set_valid(1'b0);
                chk("drop_pulse", drop_s, 1'b1);
                tick();
                chk("drop_clear", drop_s, 1'b0);
            end
            tick();
            tick();
            chk($sformatf("hold%0d", i), data_s, eb);
            set_done(1'b1);
            if (i == n - 1 && drop_end) set_valid(1'b1);
            tick();
            set_done(1'b0);
            set_valid(1'b0);
            if (i == n - 1) begin
                chk("busy_fall", busy_s, 1'b0);
                if (drop_end) chk("drop_at_end", drop_s, 1'b1);
            end else begin
                chk($sformatf("gap%0d", i), tx_start_s, 1'b1);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        reset    = 1'b1;
        bus0.temp_valid = 1'b0;
        bus1.temp_valid = 1'b0;
        bus0.temp_data  = '0;
        bus1.temp_data  = '0;
        set_done(1'b0);
        #3 reset = 1'b0;
        #1;
        chk("reset_tx_start", bus0.tx_start, 1'b0);
        chk("reset_data", bus0.data_byte, 8'h00);
        chk("reset_busy", bus0.busy, 1'b0);
        chk("reset_drop", bus0.drop_tick, 1'b0);
        chk("reset_busy1", bus1.busy, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        reset = 1'b1;
        tick();

        run_line(12'h198, 72'h2B_30_32_35_2E_35_43_0D_0A, 9, -1, -1, 1'b0);
        run_line(12'h800, 72'h2D_31_32_38_2E_30_43_0D_0A, 9, -1, -1, 1'b0);
        run_line(12'h7FF, 72'h2B_31_32_37_2E_39_43_0D_0A, 9, -1, -1, 1'b0);
        run_line(12'hFFF, 72'h2D_30_30_30_2E_30_43_0D_0A, 9, -1, -1, 1'b0);
        run_line(12'h000, 72'h2B_30_30_30_2E_30_43_0D_0A, 9, -1, -1, 1'b0);

        run_line(12'h198, 72'h2B_30_32_35_2E_35_43_0D_0A, 9, 2, -1, 1'b0);
        no_line("after_drop");
        run_line(12'h000, 72'h2B_30_30_30_2E_30_43_0D_0A, 9, -1, -1, 1'b1);
        no_line("after_end_drop");

        run_line(12'h198, 72'h2B_30_32_35_2E_35_43_0D_0A, 9, -1, 3, 1'b0);
        run_line(12'h7FF, 72'h2B_31_32_37_2E_39_43_0D_0A, 9, -1, -1, 1'b0);

        sel = 1'b1;
        run_line(12'h0A8, {56'h2B_30_31_30_2E_35_43, 16'h0000}, 7, -1, -1, 1'b0);
        no_line("crlf_off");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
